cpu6_pipeline_ctrl: RTL
=======================

# cpu6_pipeline_ctrl

Central hazard and sequencing controller for the cpu6 five-stage pipeline. Drives stall and flush (flash) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Drives the EX-stage forwarding selects. Runs a data-memory wait state machine with timeout and a stall-cycle performance counter.

## Interface
Parameters:
- TIMEOUT, 255: maximum MWAIT cycles before a data-memory access is abandoned (1..255).
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- rs1D, rs2D  in  `CPU6_RFIDX_WIDTH`  source registers of the instruction in D.
- rs1E, rs2E  in  `CPU6_RFIDX_WIDTH`  source registers of the instruction in E.
- writeregE, writeregM, writeregW  in  `CPU6_RFIDX_WIDTH`  destination registers per stage.
- regwriteE, regwriteM, regwriteW  in  1  register-write enables per stage.
- memtoregE  in  1  load in E.
- memtoregM, memwriteM  in  1  load or store in M.
- redirectE  in  1  jump or taken branch resolved in E.
- dmem_ready  in  1  data memory completes the M-stage access this cycle.
- stallF, stallD, stallE, stallM  out  1  hold the PC and the IF/ID, ID/EX, EX/MEM registers.
- flashD, flashE, flashM, flashW  out  1  load a bubble into IF/ID, ID/EX, EX/MEM, MEM/WB.
- forwardAE, forwardBE  out  2  00 register file, 10 aluoutM, 01 WB result.
- dmem_timeout  out  1  single-cycle pulse when an access is abandoned.
- stall_cycles  out  CNT_W  saturating count of cycles with stallF=1.

## Operation
- memopM = memtoregM | memwriteM.
- lduse = memtoregE & regwriteE & (writeregE != 0) & (writeregE == rs1D | writeregE == rs2D).
- FSM states: RUN, MWAIT. The wait counter wcnt is 8 bits wide.
- RUN to MWAIT when memopM & ~dmem_ready; wcnt <= 1.
- In MWAIT:
  - dmem_ready: go to RUN.
  - wcnt == TIMEOUT: pulse dmem_timeout, go to RUN.
  - otherwise: wcnt++.
- memstall = memopM & ~dmem_ready & ~(state==MWAIT & wcnt==TIMEOUT). It is combinational, so a stall is asserted in the first not-ready cycle.
- Priority 1, memstall:
  - stallF/D/E/M = 1, flashW = 1.
  - Everything else 0, including redirect and lduse.
- Priority 2, timeout cycle:
  - Stalls released, M advances.
  - flashW = 1: the abandoned load writes nothing.
- Priority 3, redirectE (no memstall): flashD = flashE = 1, no stalls. lduse is ignored because D is squashed.
- Priority 4, lduse: stallF = stallD = 1, flashE = 1.
- flashM is asserted only while reset is low.
  - Reserved for trap flush.
  - 0 in normal operation.
- Forwarding for A (B identical with rs2E):
  - 10 if regwriteM & writeregM != 0 & writeregM == rs1E.
  - Else 01 if regwriteW & writeregW != 0 & writeregW == rs1E.
  - Else 00.
  - M wins over W.
- stall_cycles increments when stallF = 1 and saturates at all-ones.

## Timing
- Reset (reset = 0, asynchronous):
  - state = RUN, wcnt = 0, stall_cycles = 0, dmem_timeout = 0.
  - flashM = 1 (combinational from ~reset); all other stall/flash outputs 0 with idle inputs.
- All stall/flash/forward outputs are combinational from the inputs and the state, with zero-cycle latency.
- dmem_timeout is registered: high the cycle after wcnt == TIMEOUT is sampled, for exactly one cycle.
- dmem_ready high in the same cycle memopM first appears: no stall, FSM stays in RUN.
- dmem_ready and timeout in the same cycle: ready wins, no dmem_timeout.
- redirectE during memstall: held in the frozen E stage and acted on the first cycle memstall drops.
- Reset asserted mid-MWAIT: immediate return to RUN, no timeout pulse.

## Structure
- The FSM state encoding (RUN=1'b0, MWAIT=1'b1) and the forward-select constants go in defines.v, next to CPU6_XLEN.
- One sub-module, cpu6_fwd_unit: the combinational forwarding selects, instantiated twice (A, B).
- Registers use cpu6_dffr-style flops with the asynchronous active-low reset.

## Test plan
- Load x5 in E, rs1D=5 -> stallF=stallD=flashE=1 for one cycle, stall_cycles +1.
- Load x0 in E, rs1D=0 -> no stall.
- redirectE=1 together with lduse -> flashD=flashE=1, stallF=0.
- memtoregM=1, dmem_ready low 3 cycles then high:
  - Stalls high for 3 cycles, flashW high for 3 cycles.
  - Release on the 4th cycle, stall_cycles = 3.
- TIMEOUT=4, dmem_ready never high:
  - Stall held, then released on the 5th cycle with flashW = 1.
  - dmem_timeout pulses once.
- writeregM=writeregW=7 with regwrite on both, rs1E=7 -> forwardAE=10.
- Repeat with regwriteM=0 -> forwardAE=01.
- reset low during MWAIT -> state RUN and counters 0 immediately, no dmem_timeout.

Source files
------------

// File: rtl/cpu6_pipeline_ctrl_pkg.sv
// Shared constants and helpers for the cpu6 pipeline hazard/sequencing controller.
package cpu6_pipeline_ctrl_pkg;

  // Register-file index width (32 architectural registers, x0 hard-wired to zero).
  localparam int RFIDX_W = 5;

  // Data-memory wait FSM encoding.
  localparam logic STATE_RUN   = 1'b0;
  localparam logic STATE_MWAIT = 1'b1;

  // EX-stage operand forward selects.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Stall/flush bundle driven onto the pipeline registers.
  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic stallM;
    logic flashD;
    logic flashE;
    logic flashM;
    logic flashW;
  } hazCtrl_t;

  // True when a writing stage targets rs. Writes to x0 never create a dependency.
  function automatic logic regHit(input logic we,
                                  input logic [RFIDX_W-1:0] wr,
                                  input logic [RFIDX_W-1:0] rs);
    return we & (wr != '0) & (wr == rs);
  endfunction

endpackage

// File: rtl/cpu6_fwd_unit.sv
// EX-stage forward select for one source operand. M beats W since it is the younger value.
module cpu6_fwd_unit
  import cpu6_pipeline_ctrl_pkg::*;
(
  input  logic               [RFIDX_W-1:0] rsE,
  input  logic                             regwriteM,
  input  logic               [RFIDX_W-1:0] writeregM,
  input  logic                             regwriteW,
  input  logic               [RFIDX_W-1:0] writeregW,
  output logic               [1:0]         fwdSel
);

  // Pick the youngest in-flight producer of rsE, else the register file.
  always_comb begin
    fwdSel = FWD_RF;
    if (regHit(regwriteM, writeregM, rsE))      fwdSel = FWD_MEM;
    else if (regHit(regwriteW, writeregW, rsE)) fwdSel = FWD_WB;
  end

endmodule

// File: rtl/cpu6_pipeline_ctrl.sv
// Central hazard controller for the cpu6 five-stage pipeline: stall/flush of the
// pipeline registers, EX forwarding, data-memory wait FSM with timeout and a
// saturating stall-cycle counter.
module cpu6_pipeline_ctrl
  import cpu6_pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RFIDX_W-1:0] rs1D,
  input  logic [RFIDX_W-1:0] rs2D,
  input  logic [RFIDX_W-1:0] rs1E,
  input  logic [RFIDX_W-1:0] rs2E,
  input  logic [RFIDX_W-1:0] writeregE,
  input  logic [RFIDX_W-1:0] writeregM,
  input  logic [RFIDX_W-1:0] writeregW,
  input  logic               regwriteE,
  input  logic               regwriteM,
  input  logic               regwriteW,
  input  logic               memtoregE,
  input  logic               memtoregM,
  input  logic               memwriteM,
  input  logic               redirectE,
  input  logic               dmem_ready,
  output logic               stallF,
  output logic               stallD,
  output logic               stallE,
  output logic               stallM,
  output logic               flashD,
  output logic               flashE,
  output logic               flashM,
  output logic               flashW,
  output logic [1:0]         forwardAE,
  output logic [1:0]         forwardBE,
  output logic               dmem_timeout,
  output logic [CNT_W-1:0]   stall_cycles
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  logic       state;
  logic [7:0] waitCnt;
  logic       memOpM;
  logic       ldUse;
  logic       toCycle;
  logic       memStall;
  logic       abandon;
  hazCtrl_t   ctrl;

  assign memOpM  = memtoregM | memwriteM;
  assign ldUse   = memtoregE & (regHit(regwriteE, writeregE, rs1D) |
                                regHit(regwriteE, writeregE, rs2D));
  assign toCycle = (state == STATE_MWAIT) & (waitCnt == TO_CNT);
  // Combinational so the very first not-ready cycle already freezes the pipe.
  assign memStall = memOpM & ~dmem_ready & ~toCycle;
  // Timeout cycle: M is released but its write-back is squashed.
  assign abandon  = toCycle & ~dmem_ready;

  // Stall/flush priority: memory stall, then timeout squash, redirect, load-use.
  always_comb begin
    ctrl        = '0;
    ctrl.flashM = ~reset;
    if (memStall) begin
      ctrl.stallF = 1'b1;
      ctrl.stallD = 1'b1;
      ctrl.stallE = 1'b1;
      ctrl.stallM = 1'b1;
      ctrl.flashW = 1'b1;
    end else begin
      if (abandon) ctrl.flashW = 1'b1;
      // A redirect squashes D, so a load-use against D is moot.
      if (redirectE) begin
        ctrl.flashD = 1'b1;
        ctrl.flashE = 1'b1;
      end else if (ldUse) begin
        ctrl.stallF = 1'b1;
        ctrl.stallD = 1'b1;
        ctrl.flashE = 1'b1;
      end
    end
  end

  assign stallF = ctrl.stallF;
  assign stallD = ctrl.stallD;
  assign stallE = ctrl.stallE;
  assign stallM = ctrl.stallM;
  assign flashD = ctrl.flashD;
  assign flashE = ctrl.flashE;
  assign flashM = ctrl.flashM;
  assign flashW = ctrl.flashW;

  // Data-memory wait FSM; ready wins over timeout in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= STATE_RUN;
      waitCnt      <= 8'd0;
      dmem_timeout <= 1'b0;
    end else begin
      dmem_timeout <= 1'b0;
      case (state)
        STATE_RUN: begin
          if (memOpM & ~dmem_ready) begin
            state   <= STATE_MWAIT;
            waitCnt <= 8'd1;
          end
        end
        default: begin
          if (dmem_ready) begin
            state <= STATE_RUN;
          end else if (waitCnt == TO_CNT) begin
            state        <= STATE_RUN;
            dmem_timeout <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
      endcase
    end
  end

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             stall_cycles <= '0;
    else if (stallF && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
  end

  // One forward unit per EX source operand (index 0 = A/rs1, 1 = B/rs2).
  logic [1:0][RFIDX_W-1:0] rsE;
  logic [1:0][1:0]         fwdSel;

  assign rsE = {rs2E, rs1E};

  for (genvar g = 0; g < 2; g++) begin : gFwd
    cpu6_fwd_unit uFwd (
      .rsE       (rsE[g]),
      .regwriteM (regwriteM),
      .writeregM (writeregM),
      .regwriteW (regwriteW),
      .writeregW (writeregW),
      .fwdSel    (fwdSel[g])
    );
  end

  assign forwardAE = fwdSel[0];
  assign forwardBE = fwdSel[1];

endmodule
